instruction_issuer: RTL and testbench

- Sequencer on the initiator side of the controller start/instruction handshake.
- Holds a small writable program buffer of 8-bit instructions: opcode [7:6], then two register fields [5:3] and [2:0].
- Issues one instruction at a time: presents the instruction, pulses start, then waits for the processor's done before issuing the next.
- Stops after prog_len instructions, or flags an error if the processor never completes.

---
 rtl/instruction_issuer.sv | 119 +++++++++++
 tb/tb_instruction_issuer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_issuer.sv
// Initiator-side sequencer: issues buffered 8-bit instructions one at a time
// over a start/done handshake, halting after prog_len or flagging a timeout.
module instruction_issuer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW:0]   prog_len,
  input  logic          run,
  input  logic          abort,
  input  logic          done,
  output logic [7:0]    instruction,
  output logic          start,
  output logic          busy,
  output logic          halted,
  output logic          error,
  output logic [AW-1:0] pc,
  output logic [AW:0]   issued
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  logic [2:0]    state;
  logic [7:0]    mem [DEPTH];
  logic [AW:0]   len;
  logic [CW-1:0] count;

  // Program buffer is deliberately left unreset.
  always_ff @(posedge clock) begin
    if (wr_en && !busy)
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      instruction <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      error       <= 1'b0;
      pc          <= '0;
      issued      <= '0;
      count       <= '0;
      len         <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (run) begin
            pc     <= '0;
            issued <= '0;
            len    <= prog_len;
            if (prog_len == '0) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              halted <= 1'b0;
              busy   <= 1'b1;
              state  <= S_FETCH;
            end
          end
        end
        S_ERR: begin
          if (abort) begin
            error <= 1'b0;
            state <= S_IDLE;
          end
        end
        // start is registered here so it is high for exactly the ISSUE cycle.
        S_FETCH: begin
          instruction <= mem[pc];
          start       <= 1'b1;
          state       <= S_ISSUE;
        end
        S_ISSUE: begin
          count <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (done) begin
            issued <= issued + 1'b1;
            if ({1'b0, pc} == len - 1'b1) begin
              halted <= 1'b1;
              busy   <= 1'b0;
              state  <= S_HALT;
            end else begin
              pc    <= pc + 1'b1;
              state <= S_FETCH;
            end
          end else if (count == CW'(TIMEOUT - 1)) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= S_ERR;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_issuer.sv
// Scoreboarded bench for instruction_issuer with a latency-accurate processor model.
module tb_instruction_issuer;
  localparam int DEPTH = 16, AW = 4, TIMEOUT = 8;

  logic          clock = 1'b0;
  logic          reset, wr_en, run, abort, done;
  logic          model_done, stray_done;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW:0]   prog_len;
  logic [7:0]    instruction;
  logic          start, busy, halted, error;
  logic [AW-1:0] pc;
  logic [AW:0]   issued;

  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] exp_q[$];
  int         start_cyc[$];
  logic [7:0] shadow [DEPTH];
  logic [7:0] sb_exp, cur_instr;
  bit         have_instr = 0;
  int         proc_mode = 0;   // 0: by opcode, 1: never done, 2: first_delay then by opcode
  int         first_delay = 0;
  int         pend = -1;

  assign done = model_done | stray_done;

  instruction_issuer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .prog_len(prog_len), .run(run), .abort(abort), .done(done),
    .instruction(instruction), .start(start), .busy(busy), .halted(halted),
    .error(error), .pc(pc), .issued(issued)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Processor model: LOAD/MOVE done at start+2, ADD/XOR at start+4.
  initial model_done = 1'b0;
  always begin
    @(negedge clock);
    if (!reset && start) begin
      if (proc_mode == 1) pend = -1;
      else if (proc_mode == 2 && first_delay > 0) begin
        pend = first_delay;
        first_delay = 0;
      end else pend = instruction[7] ? 4 : 2;
    end
    @(posedge clock);
    #1;
    model_done = 1'b0;
    if (reset) pend = -1;
    else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        model_done = 1'b1;
        pend = -1;
      end
    end
  end

  // Scoreboard monitor: each start pops one expected instruction; instruction held between starts.
  always @(negedge clock) begin
    if (reset) have_instr = 0;
    else if (start) begin
      start_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_start: instruction=%h at cycle %0d, required no start", instruction, cyc);
      end else begin
        sb_exp = exp_q.pop_front();
        if (instruction !== sb_exp) begin
          errors++;
          $display("FAIL sb_instruction: got %h, required %h", instruction, sb_exp);
        end
      end
      cur_instr = instruction;
      have_instr = 1;
    end else if (busy && have_instr) begin
      checks++;
      if (instruction !== cur_instr) begin
        errors++;
        $display("FAIL instr_stable: got %h, required %h", instruction, cur_instr);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_mem(input logic [AW-1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
    shadow[a] = d;
  endtask

  task automatic do_run(input logic [AW:0] len, output int rc);
    prog_len = len; run = 1'b1; rc = cyc;
    step();
    run = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      if (!busy) begin ok = 1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++; if (instruction !== 8'h00) begin errors++; $display("FAIL reset_instruction: got %h, required 00", instruction); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b, required 0", start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b, required 0", halted); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b, required 0", error); end
    checks++; if (pc !== '0) begin errors++; $display("FAIL reset_pc: got %0d, required 0", pc); end
    checks++; if (issued !== '0) begin errors++; $display("FAIL reset_issued: got %0d, required 0", issued); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_program();
    int rc; bit ok;
    write_mem(0, 8'h0A); write_mem(1, 8'h53); write_mem(2, 8'h8B);
    exp_q.push_back(8'h0A); exp_q.push_back(8'h53); exp_q.push_back(8'h8B);
    start_cyc.delete(); proc_mode = 0;
    do_run(3, rc);
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL prog_timeout: busy=%b, required 0 within bound", busy); end
    checks++;
    if (start_cyc.size() != 3) begin
      errors++; $display("FAIL prog_starts: got %0d, required 3", start_cyc.size());
    end else if (start_cyc[0] != rc + 2 || start_cyc[1] != start_cyc[0] + 4 || start_cyc[2] != start_cyc[1] + 4) begin
      errors++;
      $display("FAIL prog_start_timing: got %0d/%0d/%0d, required %0d/%0d/%0d",
               start_cyc[0], start_cyc[1], start_cyc[2], rc + 2, rc + 6, rc + 10);
    end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL prog_halted: got %b, required 1", halted); end
    checks++; if (issued !== 5'd3) begin errors++; $display("FAIL prog_issued: got %0d, required 3", issued); end
    checks++; if (pc !== 4'd2) begin errors++; $display("FAIL prog_pc: got %0d, required 2", pc); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL prog_sb_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_zero_len();
    int rc;
    start_cyc.delete();
    do_run(0, rc);
    checks++; if (halted !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_halt: halted=%b busy=%b, required 1/0", halted, busy); end
    repeat (4) step();
    checks++; if (start_cyc.size() != 0) begin errors++; $display("FAIL zero_start: got %0d starts, required 0", start_cyc.size()); end
    checks++; if (issued !== '0) begin errors++; $display("FAIL zero_issued: got %0d, required 0", issued); end
  endtask

  task automatic test_timeout();
    int rc, t, n;
    write_mem(0, 8'hD1);
    exp_q.push_back(8'hD1);
    start_cyc.delete(); proc_mode = 1;
    do_run(1, rc);
    n = 0;
    while (start_cyc.size() == 0 && n < 20) begin step(); n++; end
    checks++;
    if (start_cyc.size() == 0) begin
      errors++; $display("FAIL to_no_start: got 0 starts, required 1");
    end else begin
      t = start_cyc[0];
      while (cyc < t + TIMEOUT) step();
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL to_early: error=%b at start+%0d, required 0", error, TIMEOUT); end
      step();
      if (error !== 1'b1) begin errors++; $display("FAIL to_error: error=%b at start+%0d, required 1", error, TIMEOUT + 1); end
    end
    checks++; if (pc !== '0 || busy !== 1'b0) begin errors++; $display("FAIL to_state: pc=%0d busy=%b, required 0/0", pc, busy); end
    prog_len = 1; run = 1'b1; step(); run = 1'b0;
    repeat (4) step();
    checks++; if (start_cyc.size() != 1 || error !== 1'b1) begin errors++; $display("FAIL to_run_ignored: starts=%0d error=%b, required 1/1", start_cyc.size(), error); end
    abort = 1'b1; step(); abort = 1'b0;
    checks++; if (error !== 1'b0 || busy !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL to_abort: error=%b busy=%b halted=%b, required 0/0/0", error, busy, halted); end
    proc_mode = 0;
  endtask

  task automatic test_stray_done();
    stray_done = 1'b1; step(); stray_done = 1'b0; step();
    checks++; if (issued !== '0 || busy !== 1'b0) begin errors++; $display("FAIL stray_done: issued=%0d busy=%b, required 0/0", issued, busy); end
  endtask

  task automatic test_late_done();
    int rc; bit ok;
    write_mem(0, 8'h0A); write_mem(1, 8'h53);
    exp_q.push_back(8'h0A); exp_q.push_back(8'h53);
    start_cyc.delete(); proc_mode = 2; first_delay = TIMEOUT;
    do_run(2, rc);
    wait_idle(100, ok);
    checks++; if (error !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL late_error: error=%b halted=%b, required 0/1", error, halted); end
    checks++;
    if (start_cyc.size() != 2) begin errors++; $display("FAIL late_starts: got %0d, required 2", start_cyc.size()); end
    else if (start_cyc[1] != start_cyc[0] + TIMEOUT + 2) begin errors++; $display("FAIL late_gap: got %0d, required %0d", start_cyc[1] - start_cyc[0], TIMEOUT + 2); end
    checks++; if (issued !== 5'd2) begin errors++; $display("FAIL late_issued: got %0d, required 2", issued); end
    proc_mode = 0;
  endtask

  task automatic test_busy_write();
    int rc; bit ok, wrote;
    exp_q.push_back(shadow[0]); exp_q.push_back(shadow[1]);
    do_run(2, rc);
    wrote = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      if (!wrote) begin
        wr_en = 1'b1; wr_addr = 1; wr_data = 8'hFF; step(); wr_en = 1'b0; wrote = 1;
      end else step();
    end
    exp_q.push_back(shadow[0]); exp_q.push_back(shadow[1]);
    start_cyc.delete();
    do_run(2, rc);
    wait_idle(100, ok);
    checks++; if (start_cyc.size() != 2 || exp_q.size() != 0) begin errors++; $display("FAIL busy_write: starts=%0d left=%0d, required 2/0", start_cyc.size(), exp_q.size()); end
  endtask

  task automatic test_full_len();
    int rc; bit ok;
    for (int i = 0; i < DEPTH; i++) write_mem(AW'(i), 8'($urandom));
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(shadow[i]);
    start_cyc.delete();
    do_run(5'(DEPTH), rc);
    wait_idle(400, ok);
    checks++; if (start_cyc.size() != DEPTH) begin errors++; $display("FAIL full_starts: got %0d, required %0d", start_cyc.size(), DEPTH); end
    checks++; if (pc !== 4'(DEPTH - 1) || halted !== 1'b1) begin errors++; $display("FAIL full_pc: pc=%0d halted=%b, required %0d/1", pc, halted, DEPTH - 1); end
    checks++; if (issued !== 5'(DEPTH)) begin errors++; $display("FAIL full_issued: got %0d, required %0d", issued, DEPTH); end
  endtask

  task automatic test_reset_mid();
    int rc, n; bit ok;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(shadow[i]);
    start_cyc.delete();
    do_run(5'(DEPTH), rc);
    n = 0;
    while (start_cyc.size() < 6 && n < 200) begin step(); n++; end
    reset = 1'b1;
    #1;
    checks++;
    if ({instruction, start, busy, halted, error, pc, issued} !== '0) begin
      errors++;
      $display("FAIL mid_reset: instr=%h start=%b busy=%b halted=%b error=%b pc=%0d issued=%0d, required all 0",
               instruction, start, busy, halted, error, pc, issued);
    end
    exp_q.delete();
    step(); reset = 1'b0; step();
    for (int i = 0; i < 3; i++) exp_q.push_back(shadow[i]);
    start_cyc.delete();
    do_run(3, rc);
    wait_idle(100, ok);
    checks++; if (start_cyc.size() != 3 || start_cyc[0] != rc + 2) begin errors++; $display("FAIL mid_restart: starts=%0d, required 3 from cycle %0d", start_cyc.size(), rc + 2); end
    checks++; if (pc !== 4'd2 || issued !== 5'd3 || exp_q.size() != 0) begin errors++; $display("FAIL mid_final: pc=%0d issued=%0d left=%0d, required 2/3/0", pc, issued, exp_q.size()); end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; prog_len = '0;
    run = 1'b0; abort = 1'b0; stray_done = 1'b0;
    test_reset();
    test_program();
    test_zero_len();
    test_timeout();
    test_stray_done();
    test_late_done();
    test_busy_write();
    test_full_len();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "global timeout");
  end

endmodule
